// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S/TDM transmitter and the blocks built around it.
//   i2s_mode_e  : framing mode (MODE_I2S = data one Sclk after Ws edge, MODE_LJ = no delay)
//   cnt_w()     : counter width able to hold 0..n-1 (minimum 1 bit)
//   frame_bits(): bit clocks per frame for a given channel count and slot width
package i2s_pkg;

  typedef enum logic {MODE_I2S = 1'b0, MODE_LJ = 1'b1} i2s_mode_e;

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int frame_bits(input int num_ch, input int slot_w);
    return num_ch * slot_w;
  endfunction

endpackage

// File: rtl/i2s_tdm_tx_if.sv
// Frame handshake between the DSP (master) and the transmitter (slave).
//   Frame_In  : NUM_CH*DATA_W bits, channel 0 in the MSBs
//   Valid_In  : Frame_In is valid
//   Ready_Out : transmitter holding register is empty
interface i2s_tdm_tx_if #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 2
);
  logic [NUM_CH*DATA_W-1:0] Frame_In;
  logic                     Valid_In;
  logic                     Ready_Out;

  modport master (output Frame_In, output Valid_In, input Ready_Out);
  modport slave  (input Frame_In, input Valid_In, output Ready_Out);
endinterface

// File: rtl/i2s_tdm_tx_sclk_gen.sv
// Bit-clock divider. Sclk_Out toggles every SCLK_DIV Clk cycles (50 % duty).
//   Clk, Rst  : system clock, synchronous active-high reset
//   Sclk_Out  : divided bit clock, low in reset
//   Fall_Stb  : high in the Clk cycle whose edge takes Sclk_Out 1->0
//   Rise_Stb  : high in the Clk cycle whose edge takes Sclk_Out 0->1
// The strobes are combinational so a client flop updated on Fall_Stb changes
// on the same Clk edge as the Sclk_Out falling edge.
module sclk_gen
  import i2s_pkg::*;
#(
  parameter int SCLK_DIV = 4
) (
  input  logic Clk,
  input  logic Rst,
  output logic Sclk_Out,
  output logic Fall_Stb,
  output logic Rise_Stb
);
  localparam int            CW  = cnt_w(SCLK_DIV);
  localparam logic [CW-1:0] TOP = CW'(SCLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          wrap;

  assign wrap = (cnt_q == TOP);

  always_comb begin
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    sclk_d = wrap ? ~sclk_q : sclk_q;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign Sclk_Out = sclk_q;
  assign Fall_Stb = wrap & sclk_q;
  assign Rise_Stb = wrap & ~sclk_q;
endmodule

// File: rtl/i2s_tdm_tx.sv
// I2S / left-justified / TDM serial transmitter in the system clock domain.
//   Clk, Rst    : system clock, synchronous active-high reset
//   bus         : frame handshake (slave side), one holding register deep
//   Sclk_Out    : bit clock, period 2*SCLK_DIV Clk
//   Ws_Out      : word select, low for channels 0..NUM_CH/2-1
//   Sdata_Out   : serial data, MSB first, zero padded to SLOT_W
//   Frame_Start : 1-Clk pulse on the Sclk fall that starts a frame
//   Underrun    : 1-Clk pulse with Frame_Start when no frame was waiting
// All serial outputs are registered and only update on the Sclk fall strobe.
module i2s_tdm_tx
  import i2s_pkg::*;
#(
  parameter int        DATA_W   = 16,
  parameter int        NUM_CH   = 2,
  parameter int        SLOT_W   = 16,
  parameter int        SCLK_DIV = 4,
  parameter i2s_mode_e MODE     = MODE_I2S
) (
  input  logic        Clk,
  input  logic        Rst,
  i2s_tdm_tx_if.slave bus,
  output logic        Sclk_Out,
  output logic        Ws_Out,
  output logic        Sdata_Out,
  output logic        Frame_Start,
  output logic        Underrun
);
  localparam int            FB   = frame_bits(NUM_CH, SLOT_W);
  localparam int            BW   = cnt_w(FB);
  localparam int            FW   = NUM_CH * DATA_W;
  localparam logic [BW-1:0] LAST = BW'(FB - 1);

  logic fall_stb;
  logic sclk_rise_unused;

  sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk (
    .Clk      (Clk),
    .Rst      (Rst),
    .Sclk_Out (Sclk_Out),
    .Fall_Stb (fall_stb),
    .Rise_Stb (sclk_rise_unused)
  );

  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [FW-1:0] hold_q, hold_d, shift_q, shift_d;
  logic          hold_full_q, hold_full_d;
  logic          ws_q, ws_d, sdata_q, sdata_d;
  logic          fstart_q, fstart_d, under_q, under_d;
  logic          boundary, accept;
  logic [FW-1:0] src, sh;
  int            p, slot, k;

  assign boundary = fall_stb && (bit_cnt_q == LAST);
  assign accept   = bus.Valid_In && !hold_full_q;

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    ws_d        = ws_q;
    sdata_d     = sdata_q;
    fstart_d    = 1'b0;
    under_d     = 1'b0;
    p           = 0;
    slot        = 0;
    k           = 0;
    src         = shift_q;
    sh          = '0;

    // accept and a loading boundary are exclusive: accept needs an empty holder
    if (accept) begin
      hold_d      = bus.Frame_In;
      hold_full_d = 1'b1;
    end

    if (fall_stb) begin
      bit_cnt_d = boundary ? '0 : bit_cnt_q + 1'b1;
      if (boundary) begin
        fstart_d = 1'b1;
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
        end else begin
          shift_d = '0;
          under_d = 1'b1;
        end
      end

      // Ws follows the raw bit counter; data follows p, which lags by one
      // Sclk in I2S mode so the Ws edge leads each MSB.
      ws_d = (int'(bit_cnt_d) / SLOT_W) >= (NUM_CH / 2);
      if (MODE == MODE_LJ) p = int'(bit_cnt_d);
      else                 p = (bit_cnt_d == '0) ? FB - 1 : int'(bit_cnt_d) - 1;
      slot = p / SLOT_W;
      k    = p % SLOT_W;

      // In I2S mode, position 0 carries the last bit of the frame just
      // finished, which is still in shift_q during the loading cycle.
      src     = (MODE == MODE_I2S && bit_cnt_d == '0) ? shift_q : shift_d;
      sh      = src >> ((NUM_CH - 1 - slot) * DATA_W + DATA_W - 1 - k);
      sdata_d = (k < DATA_W) && sh[0];
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      bit_cnt_q   <= LAST;
      hold_q      <= '0;
      shift_q     <= '0;
      hold_full_q <= 1'b0;
      ws_q        <= 1'b0;
      sdata_q     <= 1'b0;
      fstart_q    <= 1'b0;
      under_q     <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      hold_q      <= hold_d;
      shift_q     <= shift_d;
      hold_full_q <= hold_full_d;
      ws_q        <= ws_d;
      sdata_q     <= sdata_d;
      fstart_q    <= fstart_d;
      under_q     <= under_d;
    end
  end

  assign bus.Ready_Out = !hold_full_q;
  assign Ws_Out        = ws_q;
  assign Sdata_Out     = sdata_q;
  assign Frame_Start   = fstart_q;
  assign Underrun      = under_q;
endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Directed bench: three transmitter instances (I2S stereo, LJ stereo, LJ TDM),
// one selected at a time; a monitor records Ws/Sdata at every Sclk rise and
// Frame_Start/Underrun pulses, and frames are compared to hand-computed vectors
// (bit j of the frame appears at vector bit FB-1-j).
module tb_i2s_tdm_tx;
  import i2s_pkg::*;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  logic [127:0] fin = '0;
  logic         vin = 1'b0;
  logic [1:0]   sel = 2'd0;

  i2s_tdm_tx_if #(.DATA_W(16), .NUM_CH(2)) if0 ();
  i2s_tdm_tx_if #(.DATA_W(16), .NUM_CH(2)) if1 ();
  i2s_tdm_tx_if #(.DATA_W(24), .NUM_CH(4)) if2 ();

  assign if0.Frame_In = fin[31:0];
  assign if0.Valid_In = vin && (sel == 2'd0);
  assign if1.Frame_In = fin[31:0];
  assign if1.Valid_In = vin && (sel == 2'd1);
  assign if2.Frame_In = fin[95:0];
  assign if2.Valid_In = vin && (sel == 2'd2);

  logic [2:0] sclk, ws, sd, fs, ur;

  i2s_tdm_tx #(.DATA_W(16), .NUM_CH(2), .SLOT_W(16), .SCLK_DIV(2), .MODE(MODE_I2S)) d0 (
    .Clk(Clk), .Rst(Rst), .bus(if0.slave), .Sclk_Out(sclk[0]), .Ws_Out(ws[0]),
    .Sdata_Out(sd[0]), .Frame_Start(fs[0]), .Underrun(ur[0]));
  i2s_tdm_tx #(.DATA_W(16), .NUM_CH(2), .SLOT_W(16), .SCLK_DIV(2), .MODE(MODE_LJ)) d1 (
    .Clk(Clk), .Rst(Rst), .bus(if1.slave), .Sclk_Out(sclk[1]), .Ws_Out(ws[1]),
    .Sdata_Out(sd[1]), .Frame_Start(fs[1]), .Underrun(ur[1]));
  i2s_tdm_tx #(.DATA_W(24), .NUM_CH(4), .SLOT_W(32), .SCLK_DIV(2), .MODE(MODE_LJ)) d2 (
    .Clk(Clk), .Rst(Rst), .bus(if2.slave), .Sclk_Out(sclk[2]), .Ws_Out(ws[2]),
    .Sdata_Out(sd[2]), .Frame_Start(fs[2]), .Underrun(ur[2]));

  logic m_sclk, m_ws, m_sd, m_fs, m_ur, m_rdy;
  assign m_sclk = sclk[sel];
  assign m_ws   = ws[sel];
  assign m_sd   = sd[sel];
  assign m_fs   = fs[sel];
  assign m_ur   = ur[sel];
  assign m_rdy  = (sel == 2'd0) ? if0.Ready_Out :
                  (sel == 2'd1) ? if1.Ready_Out : if2.Ready_Out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rel_cyc = 0;
  logic [1:0] rq[$];
  int         fs_pos[$];
  int         fs_cyc[$];
  logic       ur_q[$];
  logic       m_prev = 1'b0;

  initial forever begin
    @(posedge Clk);
    cyc++;
    #1;
    if (!m_prev && m_sclk) rq.push_back({m_ws, m_sd});
    if (m_fs) begin
      fs_pos.push_back(rq.size());
      fs_cyc.push_back(cyc);
      ur_q.push_back(m_ur);
    end
    m_prev = m_sclk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic rst_on(input int n);
    @(negedge Clk);
    Rst = 1'b1;
    vin = 1'b0;
    repeat (n) @(negedge Clk);
  endtask

  task automatic rst_off();
    Rst = 1'b0;
    rel_cyc = cyc;
    rq.delete();
    fs_pos.delete();
    fs_cyc.delete();
    ur_q.delete();
  endtask

  // leaves vin high; caller decides when to drop it
  task automatic push(input logic [127:0] f, input string tag);
    int n = 0;
    @(negedge Clk);
    fin = f;
    vin = 1'b1;
    while (!m_rdy && n < 2000) begin
      @(negedge Clk);
      n++;
    end
    chk({tag, "_acc"}, n < 2000, 1);
    @(negedge Clk);
    chk({tag, "_rdy_drop"}, m_rdy, 0);
  endtask

  task automatic grab(input int n, input int fb, output logic [127:0] wsv,
                      output logic [127:0] sdv, output logic urv);
    int t = 0;
    wsv = '0;
    sdv = '0;
    urv = 1'b0;
    while ((fs_pos.size() <= n || rq.size() < fs_pos[n] + fb) && t < 5000) begin
      @(negedge Clk);
      t++;
    end
    chk($sformatf("wait_f%0d", n), t < 5000, 1);
    if (t < 5000) begin
      for (int j = 0; j < fb; j++) begin
        wsv[fb-1-j] = rq[fs_pos[n]+j][1];
        sdv[fb-1-j] = rq[fs_pos[n]+j][0];
      end
      urv = ur_q[n];
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  logic [127:0] wv, dv;
  logic         uv;
  logic [31:0]  exp4 [5];
  logic         expu [5];

  initial begin
    exp4[0] = 32'h40008001; exp4[1] = 32'h8787F878; exp4[2] = 32'h891A2B3C;
    exp4[3] = 32'h80000000; exp4[4] = 32'h00000000;
    expu[0] = 0; expu[1] = 0; expu[2] = 0; expu[3] = 1; expu[4] = 1;

    // 1. reset values and first fall latency
    sel = 2'd0;
    rst_on(3);
    chk("rst_sclk", m_sclk, 0);
    chk("rst_ws", m_ws, 0);
    chk("rst_sd", m_sd, 0);
    chk("rst_fs", m_fs, 0);
    chk("rst_ur", m_ur, 0);
    chk("rst_rdy", m_rdy, 1);
    rst_off();
    repeat (8) @(negedge Clk);
    chk("fs_lat", fs_cyc.size() > 0 ? fs_cyc[0] - rel_cyc : -1, 4);
    chk("fs_ur", ur_q.size() > 0 ? ur_q[0] : 1'bx, 1);

    // 2. I2S stereo frame
    rst_on(2);
    rst_off();
    push(128'hA5C31234, "i2s");
    vin = 1'b0;
    grab(0, 32, wv, dv, uv);
    chk("i2s_ws", wv, 128'h0000FFFF);
    chk("i2s_sd", dv, 128'h52E1891A);
    chk("i2s_ur", uv, 0);

    // 4. back-pressure, ordering, I2S last-bit carry, underrun
    rst_on(2);
    rst_off();
    push(128'h80010003, "bp1");
    push(128'h0F0FF0F1, "bp2");
    push(128'h12345679, "bp3");
    vin = 1'b0;
    for (int n = 0; n < 5; n++) begin
      grab(n, 32, wv, dv, uv);
      chk($sformatf("bp_sd%0d", n), dv, exp4[n]);
      chk($sformatf("bp_ur%0d", n), uv, expu[n]);
    end
    chk("bp_ws", wv, 128'h0000FFFF);
    chk("bp_gap", fs_cyc.size() > 4 ? fs_cyc[4] - fs_cyc[3] : -1, 128);

    // 6. reset mid-frame with a frame held
    rst_on(2);
    rst_off();
    push(128'hDEADBEEF, "mr1");
    push(128'hFFFFFFFF, "mr2");
    vin = 1'b0;
    begin
      int t = 0;
      while ((fs_pos.size() == 0 || rq.size() < fs_pos[0] + 21) && t < 2000) begin
        @(negedge Clk);
        t++;
      end
      chk("mr_wait", t < 2000, 1);
    end
    chk("mr_held", m_rdy, 0);
    Rst = 1'b1;
    @(posedge Clk);
    #2;
    chk("mr_sclk", m_sclk, 0);
    chk("mr_ws", m_ws, 0);
    chk("mr_sd", m_sd, 0);
    chk("mr_rdy", m_rdy, 1);
    @(negedge Clk);
    @(negedge Clk);
    rst_off();
    grab(0, 32, wv, dv, uv);
    chk("mr_ur0", uv, 1);
    chk("mr_sd0", dv, 0);
    chk("mr_ws0", wv, 128'h0000FFFF);
    grab(1, 32, wv, dv, uv);
    chk("mr_ur1", uv, 1);
    chk("mr_sd1", dv, 0);

    // 3. left-justified stereo frame
    sel = 2'd1;
    rst_on(2);
    rst_off();
    push(128'hA5C31234, "lj");
    vin = 1'b0;
    grab(0, 32, wv, dv, uv);
    chk("lj_ws", wv, 128'h0000FFFF);
    chk("lj_sd", dv, 128'hA5C31234);

    // 5. TDM frame
    sel = 2'd2;
    rst_on(2);
    rst_off();
    push({32'h0, 24'hABCDEF, 24'h123456, 24'h800001, 24'h7FFFFF}, "tdm");
    vin = 1'b0;
    grab(0, 128, wv, dv, uv);
    chk("tdm_ws", wv, {64'h0, 64'hFFFFFFFFFFFFFFFF});
    chk("tdm_sd", dv, 128'hABCDEF00_12345600_80000100_7FFFFF00);
    chk("tdm_ur0", uv, 0);
    grab(1, 128, wv, dv, uv);
    chk("tdm_ur1", uv, 1);
    chk("tdm_gap", fs_cyc.size() > 1 ? fs_cyc[1] - fs_cyc[0] : -1, 512);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
